// File: rtl/swlight_blkdma.sv
// Switch/light register plus block DMA engine for the Zynq-side Unibus interface.
// The ARM loads a word buffer, then one request moves 1..DEPTH words in a single bus tenure.
module swlight_blkdma #(
    parameter logic [17:0] SLADDR   = 18'o777570,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned DESKEW   = 15,
    parameter int unsigned TIMEOUT  = 1023,
    parameter int unsigned GRANTDLY = 4
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [2:0]  armraddr,
    input  logic [2:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic [17:0] a_in_h,
    input  logic [1:0]  c_in_h,
    input  logic [15:0] d_in_h,
    input  logic        hltgr_in_l,
    input  logic        init_in_h,
    input  logic        msyn_in_h,
    input  logic        npg_in_l,
    input  logic        ssyn_in_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    output logic        bbsy_out_h,
    output logic        msyn_out_h,
    output logic        npr_out_h,
    output logic        sack_out_h,
    output logic        ssyn_out_h,
    output logic        hltrq_out_h,
    output logic        init_out_h,
    output logic        ac_lo_out_h,
    output logic        dc_lo_out_h,
    output logic        npg_out_l
);
    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        DmaIdle     = 3'd0,
        DmaArb      = 3'd1,
        DmaAddr     = 3'd2,
        DmaDeskew   = 3'd3,
        DmaWait     = 3'd4,
        DmaLatch    = 3'd5,
        DmaRelease  = 3'd6,
        DmaSsynWait = 3'd7
    } dma_state_t;

    dma_state_t     dmastate;
    logic           enable, haltreq, stepreq, businit, aclow, dclow, dmafail;
    logic [15:0]    switches, lights, count, done, tmr;
    logic [1:0]     dmactrl;
    logic [17:0]    curaddr;
    logic [IW-1:0]  bufidx;
    logic [15:0]    bufmem [DEPTH];
    logic [15:0]    wcount;
    logic           slave_hit, slave_rel, granted, busy;
    logic           unused_wdata;

    assign busy      = (dmastate != DmaIdle);
    assign slave_hit = enable && (a_in_h[17:1] == SLADDR[17:1]) && msyn_in_h && !ssyn_out_h;
    assign slave_rel = ssyn_out_h && !msyn_in_h;
    assign granted   = !hltgr_in_l || (npr_out_h && !npg_in_l);
    assign wcount    = (armwdata[31:16] > 16'(DEPTH)) ? 16'(DEPTH) : armwdata[31:16];
    assign unused_wdata = ^{armwdata[29], armwdata[24:18]};

    assign hltrq_out_h = haltreq;
    assign init_out_h  = businit;
    assign ac_lo_out_h = aclow;
    assign dc_lo_out_h = dclow;
    // Our own NPR must never let a grant pass downstream.
    assign npg_out_l   = npg_in_l | npr_out_h;

    always_comb begin
        armrdata = 32'hDEADBEEF;
        case (armraddr)
            3'd0: armrdata = 32'h534C3003;
            3'd1: armrdata = {lights, switches};
            3'd2: armrdata = {enable, haltreq, ~hltgr_in_l, stepreq, businit, aclow, dclow, 25'b0};
            3'd3: armrdata = {dmastate, dmafail, dmactrl, done[7:0], curaddr};
            3'd4: armrdata = {16'b0, bufmem[bufidx]};
            3'd5: armrdata = {count, 16'(bufidx)};
            default: armrdata = 32'hDEADBEEF;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            enable <= 1'b0; haltreq <= 1'b0; stepreq <= 1'b0; businit <= 1'b0;
            aclow <= 1'b0; dclow <= 1'b0; dmafail <= 1'b0; dmastate <= DmaIdle;
            switches <= '0; lights <= '0; count <= '0; done <= '0; tmr <= '0;
            dmactrl <= '0; curaddr <= '0; bufidx <= '0;
            a_out_h <= '0; c_out_h <= '0; d_out_h <= '0;
            bbsy_out_h <= 1'b0; msyn_out_h <= 1'b0; npr_out_h <= 1'b0;
            sack_out_h <= 1'b0; ssyn_out_h <= 1'b0;
        end else begin
            if (armwrite) begin
                case (armwaddr)
                    3'd1: switches <= armwdata[15:0];
                    3'd2: begin
                        enable  <= armwdata[31];
                        haltreq <= armwdata[30];
                        stepreq <= armwdata[28];
                        businit <= armwdata[27];
                        aclow   <= armwdata[26];
                        dclow   <= armwdata[25];
                    end
                    3'd3: if (!busy) begin
                        curaddr <= armwdata[17:0];
                        dmactrl <= armwdata[27:26];
                        if (armwdata[28] && count != 16'd0) begin
                            dmastate <= DmaArb;
                            done     <= '0;
                            dmafail  <= 1'b0;
                            tmr      <= '0;
                        end
                    end
                    3'd4: if (!busy) begin
                        bufmem[bufidx] <= armwdata[15:0];
                        bufidx         <= bufidx + IW'(1);
                    end
                    3'd5: if (!busy) begin
                        count  <= wcount;
                        bufidx <= armwdata[IW-1:0];
                    end
                    default: ;
                endcase
            end else if (slave_hit) begin
                ssyn_out_h <= 1'b1;
                if (!c_in_h[1])     d_out_h        <= switches;
                else if (!c_in_h[0]) lights        <= d_in_h;
                else if (a_in_h[0]) lights[15:8]   <= d_in_h[15:8];
                else                lights[7:0]    <= d_in_h[7:0];
            end else if (slave_rel) begin
                ssyn_out_h <= 1'b0;
                d_out_h    <= '0;
            end else begin
                unique case (dmastate)
                    DmaIdle: ;
                    DmaArb: begin
                        if (granted) begin
                            if (tmr == 16'(GRANTDLY - 1)) begin
                                bbsy_out_h <= 1'b1;
                                sack_out_h <= 1'b1;
                                npr_out_h  <= 1'b0;
                                tmr        <= '0;
                                dmastate   <= DmaAddr;
                            end else begin
                                tmr <= tmr + 16'd1;
                            end
                        end else begin
                            tmr       <= '0;
                            npr_out_h <= npg_in_l;
                        end
                    end
                    DmaAddr: begin
                        a_out_h  <= curaddr;
                        c_out_h  <= dmactrl;
                        d_out_h  <= dmactrl[1] ? bufmem[done[IW-1:0]] : 16'h0;
                        tmr      <= '0;
                        dmastate <= DmaDeskew;
                    end
                    DmaDeskew: begin
                        if (tmr == 16'(DESKEW)) begin
                            msyn_out_h <= 1'b1;
                            tmr        <= '0;
                            dmastate   <= DmaWait;
                        end else begin
                            tmr <= tmr + 16'd1;
                        end
                    end
                    DmaWait: begin
                        if (ssyn_in_h) begin
                            tmr      <= '0;
                            dmastate <= DmaLatch;
                        end else if (tmr == 16'(TIMEOUT - 1)) begin
                            dmafail    <= 1'b1;
                            msyn_out_h <= 1'b0;
                            tmr        <= '0;
                            dmastate   <= DmaRelease;
                        end else begin
                            tmr <= tmr + 16'd1;
                        end
                    end
                    DmaLatch: begin
                        if (tmr == 16'(DESKEW)) begin
                            if (!dmactrl[1]) bufmem[done[IW-1:0]] <= d_in_h;
                            msyn_out_h <= 1'b0;
                            done       <= done + 16'd1;
                            curaddr    <= curaddr + 18'd2;
                            tmr        <= '0;
                            dmastate   <= ((done + 16'd1) < count) ? DmaSsynWait : DmaRelease;
                        end else begin
                            tmr <= tmr + 16'd1;
                        end
                    end
                    DmaSsynWait: if (!ssyn_in_h) dmastate <= DmaAddr;
                    DmaRelease: begin
                        if (tmr == 16'(DESKEW)) begin
                            a_out_h    <= '0;
                            c_out_h    <= '0;
                            d_out_h    <= '0;
                            bbsy_out_h <= 1'b0;
                            sack_out_h <= 1'b0;
                            tmr        <= '0;
                            dmastate   <= DmaIdle;
                        end else begin
                            tmr <= tmr + 16'd1;
                        end
                    end
                endcase
            end

            // Bus INIT overrides whatever the cycle did to the drivers.
            if (init_in_h) begin
                a_out_h <= '0; c_out_h <= '0; d_out_h <= '0;
                bbsy_out_h <= 1'b0; msyn_out_h <= 1'b0; npr_out_h <= 1'b0;
                sack_out_h <= 1'b0; ssyn_out_h <= 1'b0;
                tmr <= '0;
                if (busy) begin
                    dmafail  <= 1'b1;
                    dmastate <= DmaIdle;
                end
            end
        end
    end
endmodule

// File: tb/tb_swlight_blkdma.sv
// Randomized bench for swlight_blkdma: a Unibus slave memory and grant model drive the
// bus side, and every transfer is compared against a word-list model of the block move.
module tb_swlight_blkdma;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned DESKEW   = 15;
    localparam int unsigned TIMEOUT  = 1023;
    localparam int unsigned GRANTDLY = 4;
    localparam logic [17:0] SLADDR   = 18'o777570;

    logic        CLOCK = 1'b0, RESET = 1'b1, armwrite = 1'b0;
    logic [2:0]  armraddr = '0, armwaddr = '0;
    logic [31:0] armwdata = '0, armrdata;
    logic [17:0] a_in_h = '0;
    logic [1:0]  c_in_h = '0;
    logic [15:0] d_in_h = '0;
    logic        hltgr_in_l = 1'b1, init_in_h = 1'b0, msyn_in_h = 1'b0;
    logic        npg_in_l = 1'b1, ssyn_in_h = 1'b0;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h;
    logic        bbsy_out_h, msyn_out_h, npr_out_h, sack_out_h, ssyn_out_h;
    logic        hltrq_out_h, init_out_h, ac_lo_out_h, dc_lo_out_h, npg_out_l;

    swlight_blkdma #(
        .SLADDR(SLADDR), .DEPTH(DEPTH), .DESKEW(DESKEW), .TIMEOUT(TIMEOUT), .GRANTDLY(GRANTDLY)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armraddr(armraddr),
        .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata),
        .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h), .hltgr_in_l(hltgr_in_l),
        .init_in_h(init_in_h), .msyn_in_h(msyn_in_h), .npg_in_l(npg_in_l),
        .ssyn_in_h(ssyn_in_h), .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h),
        .bbsy_out_h(bbsy_out_h), .msyn_out_h(msyn_out_h), .npr_out_h(npr_out_h),
        .sack_out_h(sack_out_h), .ssyn_out_h(ssyn_out_h), .hltrq_out_h(hltrq_out_h),
        .init_out_h(init_out_h), .ac_lo_out_h(ac_lo_out_h), .dc_lo_out_h(dc_lo_out_h),
        .npg_out_l(npg_out_l)
    );

    initial forever #5 CLOCK = ~CLOCK;

    int n_vec = 0, n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus-side models
    logic [15:0] mem [logic [17:0]];
    logic [17:0] log_a [$];
    logic [1:0]  log_c [$];
    logic [15:0] log_d [$];
    logic        log_bb [$];
    bit          noresp_en = 1'b0;
    logic [17:0] noresp_addr = '0;
    int          lat_cnt = 0, resp_lat = 0;
    int          npr_age = 0, npg_bad = 0, bbsy_rises = 0;
    logic        bbsy_prev = 1'b0;

    initial forever begin
        @(negedge CLOCK);
        if (msyn_out_h && !ssyn_in_h && !(noresp_en && a_out_h == noresp_addr)) begin
            if (lat_cnt < resp_lat) lat_cnt++;
            else begin
                if (c_out_h[1]) mem[a_out_h] = d_out_h;
                else d_in_h = mem.exists(a_out_h) ? mem[a_out_h] : 16'h0;
                log_a.push_back(a_out_h);
                log_c.push_back(c_out_h);
                log_d.push_back(d_out_h);
                log_bb.push_back(bbsy_out_h);
                ssyn_in_h = 1'b1;
                lat_cnt   = 0;
                resp_lat  = $urandom_range(0, 3);
            end
        end else if (!msyn_out_h && ssyn_in_h) begin
            ssyn_in_h = 1'b0;
            d_in_h    = 16'h0;
        end
    end

    initial forever begin
        @(negedge CLOCK);
        if (npr_out_h && !npg_out_l) npg_bad++;
        if (bbsy_out_h && !bbsy_prev) bbsy_rises++;
        bbsy_prev = bbsy_out_h;
        if (sack_out_h && !npg_in_l) begin
            npg_in_l = 1'b1;
            npr_age  = 0;
        end else if (npr_out_h && npg_in_l) begin
            npr_age++;
            if (npr_age >= 10) npg_in_l = 1'b0;
        end else if (!npr_out_h) begin
            npr_age = 0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic arm_wr(input logic [2:0] r, input logic [31:0] v);
        @(negedge CLOCK);
        armwaddr = r; armwdata = v; armwrite = 1'b1;
        @(negedge CLOCK);
        armwrite = 1'b0;
    endtask

    task automatic arm_rd(input logic [2:0] r, output logic [31:0] v);
        armraddr = r;
        #1;
        v = armrdata;
    endtask

    logic [15:0] m_buf [DEPTH];

    task automatic start_dma(input int cnt, input logic [1:0] ctrl, input logic [17:0] addr,
                             input bit halted);
        hltgr_in_l = !halted;
        npg_in_l   = 1'b1;
        arm_wr(3'd5, {16'(cnt), 16'h0});
        for (int k = 0; k < cnt; k++) begin
            m_buf[k] = 16'($urandom);
            arm_wr(3'd4, {16'h0, m_buf[k]});
        end
        if (!ctrl[1])
            for (int k = 0; k < cnt; k++) mem[addr + 18'(2 * k)] = 16'($urandom);
        log_a.delete(); log_c.delete(); log_d.delete(); log_bb.delete();
        bbsy_rises = 0;
        npg_bad    = 0;
        arm_wr(3'd3, {3'b000, 1'b1, ctrl, 8'h00, addr});
    endtask

    task automatic finish_dma(input int cnt, input logic [1:0] ctrl, input logic [17:0] addr,
                              input int fail_k, input string tag);
        logic [31:0] v;
        bit          ok;
        int          nok;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            arm_rd(3'd3, v);
            if (v[31:29] == 3'd0) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLOCK);
        end
        check_val($sformatf("%s_idle", tag), 64'(ok), 64'd1);
        nok = (fail_k >= 0) ? fail_k : cnt;
        if (!ctrl[1])
            for (int k = 0; k < nok; k++) m_buf[k] = mem[addr + 18'(2 * k)];
        check_val($sformatf("%s_nxfer", tag), 64'(log_a.size()), 64'(nok));
        for (int k = 0; k < nok && k < log_a.size(); k++)
            check_val($sformatf("%s_word%0d", tag, k),
                      {27'b0, log_a[k], log_c[k], log_d[k], log_bb[k]},
                      {27'b0, addr + 18'(2 * k), ctrl, ctrl[1] ? m_buf[k] : 16'h0, 1'b1});
        arm_rd(3'd3, v);
        check_val($sformatf("%s_reg3", tag), 64'(v),
                  64'({3'b000, fail_k >= 0, ctrl, 8'(nok), addr + 18'(2 * nok)}));
        check_val($sformatf("%s_busfree", tag),
                  {a_out_h, c_out_h, d_out_h, bbsy_out_h, sack_out_h, msyn_out_h, npr_out_h}, 0);
        check_val($sformatf("%s_tenure", tag), 64'(bbsy_rises), 64'd1);
        check_val($sformatf("%s_npg", tag), 64'(npg_bad), 64'd0);
        arm_rd(3'd5, v);
        check_val($sformatf("%s_reg5", tag), 64'(v), 64'({16'(cnt), 16'(cnt % DEPTH)}));
        for (int k = 0; k < cnt; k++) begin
            arm_wr(3'd5, {16'(cnt), 16'(k)});
            arm_rd(3'd4, v);
            check_val($sformatf("%s_buf%0d", tag, k), 64'(v), 64'({16'h0, m_buf[k]}));
        end
    endtask

    task automatic slave_cycle(input logic [17:0] a, input logic [1:0] c, input logic [15:0] d,
                               output logic [16:0] rsp, output logic [16:0] rel);
        @(negedge CLOCK);
        a_in_h = a; c_in_h = c; d_in_h = d; msyn_in_h = 1'b1;
        @(negedge CLOCK);
        rsp = {ssyn_out_h, d_out_h};
        msyn_in_h = 1'b0;
        @(negedge CLOCK);
        rel = {ssyn_out_h, d_out_h};
        a_in_h = '0;
    endtask

    initial begin
        logic [31:0] v;
        logic [16:0] rsp, rel;
        logic [15:0] sw, lt, dd;
        logic [17:0] sa, addr;
        logic [1:0]  sc, ctrl;
        bit          hit;
        int          cnt;

        // Reset state
        npg_in_l = 1'b0;
        repeat (3) @(negedge CLOCK);
        check_val("rst_npg_lo", 64'(npg_out_l), 64'd0);
        npg_in_l = 1'b1;
        #1;
        check_val("rst_npg_hi", 64'(npg_out_l), 64'd1);
        check_val("rst_outs", {a_out_h, c_out_h, d_out_h, bbsy_out_h, msyn_out_h, npr_out_h,
                  sack_out_h, ssyn_out_h, hltrq_out_h, init_out_h, ac_lo_out_h, dc_lo_out_h}, 0);
        @(negedge CLOCK);
        RESET = 1'b0;
        arm_rd(3'd0, v); check_val("id", 64'(v), 64'h534C3003);
        arm_rd(3'd1, v); check_val("rst_reg1", 64'(v), 64'd0);
        arm_rd(3'd2, v); check_val("rst_reg2", 64'(v), 64'd0);
        arm_rd(3'd3, v); check_val("rst_reg3", 64'(v), 64'd0);
        arm_rd(3'd5, v); check_val("rst_reg5", 64'(v), 64'd0);
        arm_rd(3'd6, v); check_val("reg6", 64'(v), 64'hDEADBEEF);
        arm_rd(3'd7, v); check_val("reg7", 64'(v), 64'hDEADBEEF);

        // Control register with random bits, CPU halted
        hltgr_in_l = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] w;
            w = $urandom;
            arm_wr(3'd2, w);
            arm_rd(3'd2, v);
            check_val("reg2", 64'(v), 64'({w[31], w[30], 1'b1, w[28], w[27], w[26], w[25], 25'b0}));
            check_val("ctl_outs", {hltrq_out_h, init_out_h, ac_lo_out_h, dc_lo_out_h},
                      {w[30], w[27], w[26], w[25]});
        end
        hltgr_in_l = 1'b1;

        // Slave access
        arm_wr(3'd2, 32'h8000_0000);
        sw = 16'o123456;
        arm_wr(3'd1, {16'h0, sw});
        slave_cycle(SLADDR, 2'b00, 16'h0, rsp, rel);
        check_val("sl_dati", rsp, {1'b1, sw});
        check_val("sl_dati_rel", rel, 0);
        lt = 16'($urandom);
        slave_cycle(SLADDR, 2'b10, lt, rsp, rel);
        check_val("sl_dato", rsp, {1'b1, 16'h0});
        slave_cycle(SLADDR | 18'd1, 2'b11, 16'h5A00, rsp, rel);
        lt = {8'h5A, lt[7:0]};
        arm_rd(3'd1, v);
        check_val("sl_datob", 64'(v), 64'({lt, sw}));
        for (int i = 0; i < 10; i++) begin
            sa = ($urandom_range(0, 2) == 0) ? 18'($urandom) : (SLADDR | 18'($urandom_range(0, 1)));
            sc = 2'($urandom);
            dd = 16'($urandom);
            hit = (sa[17:1] == SLADDR[17:1]);
            slave_cycle(sa, sc, dd, rsp, rel);
            if (hit && sc == 2'b10) lt = dd;
            if (hit && sc == 2'b11) begin
                if (sa[0]) lt[15:8] = dd[15:8];
                else       lt[7:0]  = dd[7:0];
            end
            check_val("sl_rnd_rsp", rsp, {hit, (hit && !sc[1]) ? sw : 16'h0});
            check_val("sl_rnd_rel", rel, 0);
            arm_rd(3'd1, v);
            check_val("sl_rnd_lights", 64'(v), 64'({lt, sw}));
        end
        arm_wr(3'd2, 32'h0);
        slave_cycle(SLADDR, 2'b00, 16'h0, rsp, rel);
        check_val("sl_disabled", rsp, 0);

        // Directed block transfers
        start_dma(4, 2'b10, 18'o001000, 1'b1);
        finish_dma(4, 2'b10, 18'o001000, -1, "blkwr");
        start_dma(3, 2'b00, 18'o004000, 1'b0);
        finish_dma(3, 2'b00, 18'o004000, -1, "nprrd");
        start_dma(4, 2'b10, 18'o777774, 1'b1);
        finish_dma(4, 2'b10, 18'o777774, -1, "wrap");

        // Timeout on the second word
        noresp_en = 1'b1;
        noresp_addr = 18'o001002;
        start_dma(4, 2'b10, 18'o001000, 1'b1);
        finish_dma(4, 2'b10, 18'o001000, 1, "tmo");
        noresp_en = 1'b0;

        // Randomized transfers
        for (int i = 0; i < 6; i++) begin
            cnt  = $urandom_range(1, DEPTH);
            ctrl = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
            addr = 18'($urandom) & ~18'd1;
            start_dma(cnt, ctrl, addr, bit'($urandom_range(0, 1)));
            finish_dma(cnt, ctrl, addr, -1, $sformatf("rnd%0d", i));
        end

        // Register writes while busy are ignored
        start_dma(4, 2'b10, 18'o002000, 1'b1);
        repeat (30) @(negedge CLOCK);
        arm_wr(3'd5, {16'd1, 16'd7});
        arm_wr(3'd4, 32'h0000_FFFF);
        arm_wr(3'd3, {3'b000, 1'b1, 2'b00, 8'h00, 18'o000100});
        finish_dma(4, 2'b10, 18'o002000, -1, "busy");

        // Count boundaries
        arm_wr(3'd5, 32'h0);
        arm_wr(3'd3, {3'b000, 1'b1, 2'b10, 8'h00, 18'o003000});
        repeat (8) @(negedge CLOCK);
        arm_rd(3'd3, v);
        check_val("cnt0_state", 64'(v[31:29]), 64'd0);
        check_val("cnt0_bus", 64'({bbsy_out_h, npr_out_h}), 64'd0);
        arm_wr(3'd5, {16'd300, 16'd21});
        arm_rd(3'd5, v);
        check_val("clamp", 64'(v), 64'({16'(DEPTH), 16'd5}));

        // INIT mid-transfer
        start_dma(6, 2'b10, 18'o005000, 1'b1);
        for (int i = 0; i < 5000 && log_a.size() < 2; i++) @(negedge CLOCK);
        check_val("init_reach", 64'(log_a.size() >= 2), 64'd1);
        @(negedge CLOCK);
        init_in_h = 1'b1;
        @(negedge CLOCK);
        init_in_h = 1'b0;
        check_val("init_bus", {a_out_h, c_out_h, d_out_h, bbsy_out_h, sack_out_h, msyn_out_h,
                  npr_out_h, ssyn_out_h}, 0);
        arm_rd(3'd3, v);
        check_val("init_reg3", 64'(v[31:28]), 64'h1);

        // RESET mid-transfer
        arm_wr(3'd2, 32'hC000_0000);
        start_dma(6, 2'b10, 18'o006000, 1'b1);
        for (int i = 0; i < 5000 && log_a.size() < 1; i++) @(negedge CLOCK);
        check_val("rst_reach", 64'(log_a.size() >= 1), 64'd1);
        RESET = 1'b1;
        repeat (2) @(negedge CLOCK);
        check_val("mrst_outs", {a_out_h, c_out_h, d_out_h, bbsy_out_h, msyn_out_h, npr_out_h,
                  sack_out_h, ssyn_out_h, hltrq_out_h, init_out_h, ac_lo_out_h, dc_lo_out_h}, 0);
        RESET = 1'b0;
        arm_rd(3'd2, v); check_val("mrst_reg2", 64'(v), 64'h2000_0000);
        arm_rd(3'd3, v); check_val("mrst_reg3", 64'(v), 64'd0);
        arm_rd(3'd5, v); check_val("mrst_reg5", 64'(v), 64'd0);
        check_val("mrst_npg", 64'(npg_out_l), 64'(npg_in_l));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
